// File: rtl/alu_mips_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mips_seq
// Description : Multi-cycle MIPS ALU with valid/ready handshake, registered
//               result and flags, iterative SLL and shift-add MUL.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mips_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] BussA,
   input  logic [WIDTH-1:0] BussB,
   input  logic [2:0]       ALUControl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Output,
   output logic             CarryOut,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_busy = 2'd1;
   localparam logic [1:0] c_st_done = 2'd2;

   localparam logic [2:0] c_op_add = 3'b000;
   localparam logic [2:0] c_op_sub = 3'b001;
   localparam logic [2:0] c_op_and = 3'b010;
   localparam logic [2:0] c_op_or  = 3'b011;
   localparam logic [2:0] c_op_xor = 3'b100;
   localparam logic [2:0] c_op_slt = 3'b101;
   localparam logic [2:0] c_op_sll = 3'b110;
   localparam logic [2:0] c_op_mul = 3'b111;

   localparam logic [SHW:0] c_mul_iter = (SHW+1)'(WIDTH);
   localparam logic [SHW:0] c_cnt_one  = (SHW+1)'(1);

   logic [1:0]         r_state;
   logic [1:0]         w_next_state;
   logic [2:0]         r_op;
   logic [SHW:0]       r_cnt;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_result;
   logic               r_carry;
   logic               r_ovf;
   logic               r_zero;
   logic               r_neg;

   logic               w_accept;
   logic               w_sll_zero;
   logic               w_multi;
   logic               w_last;
   logic               w_is_sub;
   logic [WIDTH-1:0]   w_b_op;
   logic [WIDTH:0]     w_sum;
   logic               w_sum_ovf;
   logic [WIDTH-1:0]   w_fast_res;
   logic               w_fast_c;
   logic               w_fast_v;
   logic [2*WIDTH-1:0] w_acc_next;
   logic [WIDTH-1:0]   w_shift_next;
   logic               w_load_en;
   logic [WIDTH-1:0]   w_load_res;
   logic               w_load_c;
   logic               w_load_v;

   assign w_accept   = (r_state == c_st_idle) && in_valid;
   assign w_sll_zero = (BussB[SHW-1:0] == '0);
   assign w_multi    = ((ALUControl == c_op_sll) && !w_sll_zero) || (ALUControl == c_op_mul);
   assign w_last     = (r_cnt == c_cnt_one);

   // SUB and SLT share the A + ~B + 1 adder
   assign w_is_sub  = (ALUControl == c_op_sub) || (ALUControl == c_op_slt);
   assign w_b_op    = w_is_sub ? ~BussB : BussB;
   assign w_sum     = {1'b0, BussA} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_is_sub};
   assign w_sum_ovf = (BussA[WIDTH-1] == w_b_op[WIDTH-1]) && (w_sum[WIDTH-1] != BussA[WIDTH-1]);

   assign w_acc_next   = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_shift_next = {r_mcand[WIDTH-2:0], 1'b0};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_idle: if (in_valid) w_next_state = w_multi ? c_st_busy : c_st_done;
         c_st_busy: if (w_last) w_next_state = c_st_done;
         c_st_done: if (out_ready) w_next_state = c_st_idle;
         default:   w_next_state = c_st_idle;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == c_st_idle);
      out_valid = (r_state == c_st_done);
   end

   always_comb begin
      w_fast_res = '0;
      w_fast_c   = 1'b0;
      w_fast_v   = 1'b0;
      case (ALUControl)
         c_op_add: begin
            w_fast_res = w_sum[WIDTH-1:0];
            w_fast_c   = w_sum[WIDTH];
            w_fast_v   = w_sum_ovf;
         end
         c_op_sub: begin
            w_fast_res = w_sum[WIDTH-1:0];
            w_fast_c   = ~w_sum[WIDTH];
            w_fast_v   = w_sum_ovf;
         end
         c_op_and: w_fast_res = BussA & BussB;
         c_op_or:  w_fast_res = BussA | BussB;
         c_op_xor: w_fast_res = BussA ^ BussB;
         c_op_slt: w_fast_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_sum_ovf};
         c_op_sll: w_fast_res = BussA;
         default:  w_fast_res = '0;
      endcase
   end

   // Result register is written either in the accept cycle or on the last BUSY cycle
   always_comb begin
      w_load_en  = 1'b0;
      w_load_res = w_fast_res;
      w_load_c   = w_fast_c;
      w_load_v   = w_fast_v;
      if (w_accept && !w_multi) begin
         w_load_en = 1'b1;
      end else if ((r_state == c_st_busy) && w_last) begin
         w_load_en = 1'b1;
         if (r_op == c_op_mul) begin
            w_load_res = w_acc_next[WIDTH-1:0];
            w_load_c   = 1'b0;
            w_load_v   = |w_acc_next[2*WIDTH-1:WIDTH];
         end else begin
            w_load_res = w_shift_next;
            w_load_c   = r_mcand[WIDTH-1];
            w_load_v   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_op     <= '0;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b1;
         r_neg    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op     <= ALUControl;
            r_mcand  <= {{WIDTH{1'b0}}, BussA};
            r_mplier <= BussB;
            r_acc    <= '0;
            r_cnt    <= (ALUControl == c_op_mul) ? c_mul_iter : {1'b0, BussB[SHW-1:0]};
         end else if (r_state == c_st_busy) begin
            // SLL reuses the multiplicand register as its working shifter
            r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_acc    <= w_acc_next;
            r_cnt    <= r_cnt - c_cnt_one;
         end
         if (w_load_en) begin
            r_result <= w_load_res;
            r_carry  <= w_load_c;
            r_ovf    <= w_load_v;
            r_zero   <= (w_load_res == '0);
            r_neg    <= w_load_res[WIDTH-1];
         end
      end
   end

   assign Output   = r_result;
   assign CarryOut = r_carry;
   assign overflow = r_ovf;
   assign zero     = r_zero;
   assign negative = r_neg;

endmodule
`default_nettype wire

// File: tb/tb_alu_mips_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mips_seq
// Description : Self-checking bench for alu_mips_seq at WIDTH=32 and WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mips_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, out_ready, sel8;
   logic iv32, ir32, ov32, c32, v32, z32, n32;
   logic [2:0] op32;
   logic [31:0] a32, b32, r32;
   logic iv8, ir8, ov8, c8, v8, z8, n8;
   logic [2:0] op8;
   logic [7:0] a8, b8, r8;

   int n_tests = 0;
   int n_fail  = 0;

   alu_mips_seq #(.WIDTH(32)) u_dut32 (
      .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
      .BussA(a32), .BussB(b32), .ALUControl(op32), .out_valid(ov32),
      .out_ready(out_ready), .Output(r32), .CarryOut(c32), .overflow(v32),
      .zero(z32), .negative(n32));

   alu_mips_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
      .BussA(a8), .BussB(b8), .ALUControl(op8), .out_valid(ov8),
      .out_ready(out_ready), .Output(r8), .CarryOut(c8), .overflow(v8),
      .zero(z8), .negative(n8));

   logic        mux_ir, mux_ov;
   logic [35:0] mux_out;
   assign mux_ir  = sel8 ? ir8 : ir32;
   assign mux_ov  = sel8 ? ov8 : ov32;
   assign mux_out = sel8 ? {24'b0, r8, c8, v8, z8, n8} : {r32, c32, v32, z32, n32};

   typedef struct packed {
      logic [31:0] res;
      logic c, v, z, n;
   } exp_t;

   typedef struct {
      bit          w8;
      logic [2:0]  op;
      logic [31:0] a, b, res;
      logic        c, v, z, n;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values
   function automatic exp_t model(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [63:0] mask, ua, ub, r;
      longint sa, sb, s, lim;
      int sh;
      mask = (64'd1 << w) - 64'd1;
      ua = {32'b0, a} & mask;
      ub = {32'b0, b} & mask;
      lim = longint'(1) <<< (w - 1);
      sa = longint'(ua); if (ua[w-1]) sa = sa - (longint'(1) <<< w);
      sb = longint'(ub); if (ub[w-1]) sb = sb - (longint'(1) <<< w);
      e.c = 1'b0; e.v = 1'b0; r = 64'd0;
      case (op)
         3'd0: begin r = ua + ub; e.c = (r > mask); s = sa + sb; e.v = (s >= lim) || (s < -lim); end
         3'd1: begin r = ua - ub; e.c = (ua < ub); s = sa - sb; e.v = (s >= lim) || (s < -lim); end
         3'd2: r = ua & ub;
         3'd3: r = ua | ub;
         3'd4: r = ua ^ ub;
         3'd5: r = (sa < sb) ? 64'd1 : 64'd0;
         3'd6: begin
            sh = int'(ub % 64'(w));
            r = ua << sh;
            if (sh != 0) e.c = ua[w - sh];
         end
         default: begin r = ua * ub; e.v = ((r >> w) != 64'd0); end
      endcase
      r = r & mask;
      e.res = r[31:0];
      e.z = (r == 64'd0);
      e.n = r[w-1];
      return e;
   endfunction

   function automatic int mlat(input int w, input logic [2:0] op, input logic [31:0] b);
      int sh;
      sh = int'(b % 32'(w));
      if (op == 3'd6) return (sh == 0) ? 1 : sh + 1;
      if (op == 3'd7) return w + 1;
      return 1;
   endfunction

   task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (sel8) begin iv8 = v; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
      else begin iv32 = v; op32 = op; a32 = a; b32 = b; end
   endtask

   task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input exp_t e, input int elat, input string name);
      int lat;
      int bud = 0;
      while (!mux_ir && bud < 200) begin @(posedge clk); #1; bud++; end
      if (!mux_ir) chk({name, " in_ready timeout"}, 64'(mux_ir), 64'd1);
      drive(1'b1, op, a, b);
      @(posedge clk); #1;
      drive(1'b0, 3'($urandom), $urandom, $urandom);
      lat = 1;
      while (!mux_ov && lat < 200) begin @(posedge clk); #1; lat++; end
      chk({name, " latency"}, 64'(lat), 64'(elat));
      chk({name, " result"}, 64'(mux_out), 64'(e));
      if (out_ready) begin
         @(posedge clk); #1;
         chk({name, " back to idle"}, {62'b0, mux_ir, mux_ov}, 64'b10);
      end
   endtask

   vec_t tbl[20];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      exp_t e;
      logic [2:0] op;
      logic [31:0] a, b;
      bit seen;

      tbl[0]  = '{1'b0, 3'd0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, 1};
      tbl[1]  = '{1'b0, 3'd0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1};
      tbl[2]  = '{1'b0, 3'd1, 32'h3,        32'h5,        32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1, 1};
      tbl[3]  = '{1'b0, 3'd1, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1};
      tbl[4]  = '{1'b0, 3'd1, 32'h5,        32'h5,        32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1};
      tbl[5]  = '{1'b0, 3'd5, 32'h80000000, 32'h1,        32'h1,        1'b0, 1'b0, 1'b0, 1'b0, 1};
      tbl[6]  = '{1'b0, 3'd5, 32'h1,        32'h80000000, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1};
      tbl[7]  = '{1'b0, 3'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      tbl[8]  = '{1'b0, 3'd3, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
      tbl[9]  = '{1'b0, 3'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0, 1'b0, 1'b1, 1};
      tbl[10] = '{1'b0, 3'd6, 32'h80000001, 32'h4,        32'h10,       1'b0, 1'b0, 1'b0, 1'b0, 5};
      tbl[11] = '{1'b0, 3'd6, 32'h80000001, 32'h1,        32'h2,        1'b1, 1'b0, 1'b0, 1'b0, 2};
      tbl[12] = '{1'b0, 3'd6, 32'h12345678, 32'h0,        32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      tbl[13] = '{1'b0, 3'd7, 32'h00010000, 32'h00010000, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 33};
      tbl[14] = '{1'b0, 3'd7, 32'd1234,     32'd5678,     32'd7006652,  1'b0, 1'b0, 1'b0, 1'b0, 33};
      tbl[15] = '{1'b0, 3'd6, 32'h1,        32'hFFFFFFE3, 32'h8,        1'b0, 1'b0, 1'b0, 1'b0, 4};
      tbl[16] = '{1'b1, 3'd0, 32'h7F,       32'h1,        32'h80,       1'b0, 1'b1, 1'b0, 1'b1, 1};
      tbl[17] = '{1'b1, 3'd6, 32'h81,       32'h4,        32'h10,       1'b0, 1'b0, 1'b0, 1'b0, 5};
      tbl[18] = '{1'b1, 3'd6, 32'h81,       32'h1,        32'h02,       1'b1, 1'b0, 1'b0, 1'b0, 2};
      tbl[19] = '{1'b1, 3'd7, 32'h10,       32'h10,       32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 9};

      sel8 = 1'b0; out_ready = 1'b1; reset = 1'b1;
      iv32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
      iv8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset values on both widths
      chk("reset state w32", {ir32, ov32, r32, c32, v32, z32, n32}, {2'b10, 32'h0, 4'b0010});
      chk("reset state w8",  {ir8, ov8, r8, c8, v8, z8, n8},       {2'b10, 8'h0, 4'b0010});

      foreach (tbl[i]) begin
         sel8 = tbl[i].w8;
         e = '{tbl[i].res, tbl[i].c, tbl[i].v, tbl[i].z, tbl[i].n};
         run(tbl[i].op, tbl[i].a, tbl[i].b, e, tbl[i].lat, $sformatf("vec%0d", i));
      end

      // Reset on the 5th BUSY cycle of MUL 7x9, with a coincident in_valid
      sel8 = 1'b0;
      drive(1'b1, 3'd7, 32'd7, 32'd9);
      @(posedge clk); #1;
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      repeat (4) begin @(posedge clk); #1; end
      reset = 1'b1;
      drive(1'b1, 3'd0, 32'd1, 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      chk("reset mid-MUL", {ir32, ov32, r32, z32}, {2'b10, 32'h0, 1'b1});
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (ov32) seen = 1'b1; end
      chk("no result after reset", 64'(seen), 64'd0);

      // Backpressure: DONE held for 10 cycles while in_valid pulses
      out_ready = 1'b0;
      run(3'd0, 32'd1, 32'd2, model(32, 3'd0, 32'd1, 32'd2), 1, "bp add");
      for (int k = 0; k < 10; k++) begin
         drive(k[0], 3'd1, $urandom, $urandom);
         @(posedge clk); #1;
         chk($sformatf("bp hold %0d", k), {ir32, ov32, r32, c32, v32, z32, n32}, {2'b01, 32'd3, 4'b0000});
      end
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp release", {ir32, ov32}, 2'b10);

      // Randomised operations against the reference model
      for (int k = 0; k < 80; k++) begin
         sel8 = (k >= 60);
         op = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 3);
         if ($urandom_range(0, 5) == 0) a = b;
         e = model(sel8 ? 8 : 32, op, a, b);
         run(op, a, b, e, mlat(sel8 ? 8 : 32, op, b), $sformatf("rnd%0d op%0d", k, op));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
